// File: rtl/pe_pkg.sv
// Shared definitions for the PE bit-serial framing logic.
// Latency: none (types, constants and a constant function only).
// Backpressure: not applicable.
package pe_pkg;

    localparam int BITWIDTH_DEF = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Ceiling log2; returns 0 for 1 so a 1-bit word still gets a 1-bit counter.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bitserial_holdbuf.sv
// One-word holding buffer with valid/ready on the parallel side.
// Latency: word visible on pend the cycle after acceptance.
// Backpressure: word_ready low while full or in reset; freed by load.
module bitserial_holdbuf
    import pe_pkg::*;
#(
    parameter int BITWIDTH = BITWIDTH_DEF
) (
    input  logic                fast_clk,
    input  logic                rst,
    input  logic [BITWIDTH-1:0] word_in,
    input  logic                word_valid,
    output logic                word_ready,
    input  logic                load,
    output logic [BITWIDTH-1:0] pend,
    output logic                pend_full
);

    logic accept;

    assign word_ready = !pend_full && !rst;
    assign accept     = word_valid && word_ready;

    // accept needs an empty slot and load needs a full one, so they never coincide
    always_ff @(posedge fast_clk) begin
        if (rst) begin
            pend      <= '0;
            pend_full <= 1'b0;
        end else if (accept) begin
            pend      <= word_in;
            pend_full <= 1'b1;
        end else if (load) begin
            pend_full <= 1'b0;
        end
    end

endmodule

// File: rtl/bitserial_tx.sv
// Bit-serial word transmitter: parallel words in, one bit per fast_clk out.
// Latency: first bit valid 2 edges after acceptance from idle; gapless back-to-back.
// Backpressure: bit_hold freezes the shifter; word_ready drops while the buffer is full.
module bitserial_tx
    import pe_pkg::*;
#(
    parameter int BITWIDTH  = BITWIDTH_DEF,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                fast_clk,
    input  logic                rst,
    input  logic [BITWIDTH-1:0] word_in,
    input  logic                word_valid,
    output logic                word_ready,
    input  logic                bit_hold,
    output logic                bit_out,
    output logic                bit_valid,
    output logic                bit_first,
    output logic                bit_last
);

    localparam int            CW       = clog2(BITWIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BITWIDTH - 1);

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [BITWIDTH-1:0] sreg, sreg_nxt;
    logic [BITWIDTH-1:0] pend;
    logic                pend_full;
    logic                last_bit;
    logic                load;

    assign last_bit = (state == ST_SHIFT) && (cnt == CNT_LAST);
    assign load     = pend_full && ((state == ST_IDLE) || (last_bit && !bit_hold));

    bitserial_holdbuf #(
        .BITWIDTH (BITWIDTH)
    ) u_holdbuf (
        .fast_clk   (fast_clk),
        .rst        (rst),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .load       (load),
        .pend       (pend),
        .pend_full  (pend_full)
    );

    always_ff @(posedge fast_clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            sreg  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sreg  <= sreg_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sreg_nxt  = sreg;
        if (load) begin
            sreg_nxt  = pend;
            cnt_nxt   = '0;
            state_nxt = ST_SHIFT;
        end else if ((state == ST_SHIFT) && !bit_hold) begin
            // shifting in zeros leaves sreg cleared, so bit_out idles low
            sreg_nxt = LSB_FIRST ? (sreg >> 1) : (sreg << 1);
            if (cnt == CNT_LAST) begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end
    end

    assign bit_out   = LSB_FIRST ? sreg[0] : sreg[BITWIDTH-1];
    assign bit_valid = (state == ST_SHIFT) && !bit_hold;
    assign bit_first = bit_valid && (cnt == '0);
    assign bit_last  = bit_valid && (cnt == CNT_LAST);

endmodule

// File: tb/tb_bitserial_tx.sv
// Directed and random checks of bitserial_tx in three configurations
// (8-bit LSB-first, 4-bit MSB-first, 1-bit) against a per-word bit-list model.
module tb_bitserial_tx;

    logic       fast_clk = 1'b0;
    logic       rst;

    logic [7:0] wi8;
    logic       wv8, h8, wr8, bo8, bv8, bf8, bl8;
    logic [3:0] wi4;
    logic       wv4, h4, wr4, bo4, bv4, bf4, bl4;
    logic [0:0] wi1;
    logic       wv1, h1, wr1, bo1, bv1, bf1, bl1;

    int nchk = 0;
    int nerr = 0;

    // expected stream per DUT: {bit, first, last}
    logic [2:0] q8[$];
    logic [2:0] q4[$];
    logic [2:0] q1[$];

    always #5 fast_clk = ~fast_clk;

    bitserial_tx #(.BITWIDTH(8), .LSB_FIRST(1'b1)) u_d8 (
        .fast_clk(fast_clk), .rst(rst), .word_in(wi8), .word_valid(wv8), .word_ready(wr8),
        .bit_hold(h8), .bit_out(bo8), .bit_valid(bv8), .bit_first(bf8), .bit_last(bl8));

    bitserial_tx #(.BITWIDTH(4), .LSB_FIRST(1'b0)) u_d4 (
        .fast_clk(fast_clk), .rst(rst), .word_in(wi4), .word_valid(wv4), .word_ready(wr4),
        .bit_hold(h4), .bit_out(bo4), .bit_valid(bv4), .bit_first(bf4), .bit_last(bl4));

    bitserial_tx #(.BITWIDTH(1), .LSB_FIRST(1'b1)) u_d1 (
        .fast_clk(fast_clk), .rst(rst), .word_in(wi1), .word_valid(wv1), .word_ready(wr1),
        .bit_hold(h1), .bit_out(bo1), .bit_valid(bv1), .bit_first(bf1), .bit_last(bl1));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input int d, input int w, input bit lsb, input logic [63:0] val);
        logic [2:0] e;
        int idx;
        for (int i = 0; i < w; i++) begin
            idx = lsb ? i : (w - 1 - i);
            e = {val[idx], (i == 0), (i == w - 1)};
            case (d)
                0:       q8.push_back(e);
                1:       q4.push_back(e);
                default: q1.push_back(e);
            endcase
        end
    endtask

    task automatic check_out(input int d, input string nm, input logic o, input logic v,
                             input logic f, input logic l, input logic hold);
        logic [2:0] e;
        int sz;
        case (d)
            0:       sz = q8.size();
            1:       sz = q4.size();
            default: sz = q1.size();
        endcase
        if (hold) chk({nm, "_valid_in_hold"}, 64'(v), 64'(0));
        if (v) begin
            chk({nm, "_bit_expected"}, 64'(sz > 0), 64'(1));
            if (sz > 0) begin
                case (d)
                    0:       e = q8.pop_front();
                    1:       e = q4.pop_front();
                    default: e = q1.pop_front();
                endcase
                chk({nm, "_bit_out"}, 64'(o), 64'(e[2]));
                chk({nm, "_bit_first"}, 64'(f), 64'(e[1]));
                chk({nm, "_bit_last"}, 64'(l), 64'(e[0]));
            end
        end else begin
            chk({nm, "_first_idle"}, 64'(f), 64'(0));
            chk({nm, "_last_idle"}, 64'(l), 64'(0));
        end
    endtask

    // one cycle: check settled outputs, record accepts in the model, clock
    task automatic step();
        #1;
        if (!rst) begin
            check_out(0, "d8", bo8, bv8, bf8, bl8, h8);
            check_out(1, "d4", bo4, bv4, bf4, bl4, h4);
            check_out(2, "d1", bo1, bv1, bf1, bl1, h1);
            if (wv8 && wr8) push_word(0, 8, 1'b1, 64'(wi8));
            if (wv4 && wr4) push_word(1, 4, 1'b0, 64'(wi4));
            if (wv1 && wr1) push_word(2, 1, 1'b1, 64'(wi1));
        end else begin
            q8.delete();
            q4.delete();
            q1.delete();
        end
        @(posedge fast_clk);
        #1;
    endtask

    initial begin
        logic [7:0] a5;
        logic [7:0] b2b [3];
        logic [3:0] e4;
        logic [0:0] l1 [3];
        int k, j, gaps, pulses;
        logic acc;

        rst = 1'b1;
        wi8 = '0; wv8 = 1'b0; h8 = 1'b0;
        wi4 = '0; wv4 = 1'b0; h4 = 1'b0;
        wi1 = '0; wv1 = 1'b0; h1 = 1'b0;

        // reset state
        repeat (2) step();
        chk("rst_word_ready", 64'(wr8), 64'(0));
        chk("rst_bit_out", 64'(bo8), 64'(0));
        chk("rst_bit_valid", 64'(bv8), 64'(0));
        chk("rst_bit_first", 64'(bf8), 64'(0));
        chk("rst_bit_last", 64'(bl8), 64'(0));
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 64'(wr8), 64'(1));

        // single word 8'hA5, LSB first
        a5 = 8'hA5;
        wi8 = a5; wv8 = 1'b1;
        step();
        wv8 = 1'b0;
        chk("lat_edge1_idle", 64'(bv8), 64'(0));
        chk("ready_fall_after_accept", 64'(wr8), 64'(0));
        step();
        chk("lat_edge2_valid", 64'(bv8), 64'(1));
        chk("ready_rise_after_load", 64'(wr8), 64'(1));
        for (int i = 0; i < 8; i++) begin
            chk("a5_valid", 64'(bv8), 64'(1));
            chk("a5_bit", 64'(bo8), 64'(a5[i]));
            step();
        end
        chk("a5_idle_after", 64'(bv8), 64'(0));

        // back-to-back with word_valid held high
        b2b[0] = 8'h0F; b2b[1] = 8'hF0; b2b[2] = 8'h3C;
        k = 0; j = 0; gaps = 0;
        wi8 = b2b[0]; wv8 = 1'b1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (bv8) begin
                if (j < 17) chk("b2b_word_ready", 64'(wr8), 64'((j % 8) == 0));
                chk("b2b_first_pos", 64'(bf8), 64'((j % 8) == 0));
                j++;
            end else if (j > 0 && j < 24) begin
                gaps++;
            end
            acc = wv8 && wr8;
            step();
            if (acc) begin
                k++;
                if (k < 3) wi8 = b2b[k];
                else wv8 = 1'b0;
            end
        end
        chk("b2b_valid_count", 64'(j), 64'(24));
        chk("b2b_gaps", 64'(gaps), 64'(0));

        // stall of 5 cycles after the 3rd bit of 8'h81
        wi8 = 8'h81; wv8 = 1'b1;
        step();
        wv8 = 1'b0;
        step();
        repeat (3) step();
        h8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_valid_low", 64'(bv8), 64'(0));
            chk("stall_bit_frozen", 64'(bo8), 64'(0));
            step();
        end
        h8 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_resume_valid", 64'(bv8), 64'(1));
            chk("stall_resume_last", 64'(bl8), 64'(i == 4));
            step();
        end
        chk("stall_idle_after", 64'(bv8), 64'(0));

        // MSB first, 4-bit word 4'b1100
        e4 = 4'b1100;
        wi4 = e4; wv4 = 1'b1;
        step();
        wv4 = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("msb_valid", 64'(bv4), 64'(1));
            chk("msb_bit", 64'(bo4), 64'(e4[3-i]));
            step();
        end
        chk("msb_idle_after", 64'(bv4), 64'(0));

        // reset after the 4th bit of 8'hFF with 8'h00 pending
        wi8 = 8'hFF; wv8 = 1'b1;
        step();
        wv8 = 1'b0;
        step();
        wi8 = 8'h00; wv8 = 1'b1;
        step();
        wv8 = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        #1;
        chk("midrst_ready_in_rst", 64'(wr8), 64'(0));
        step();
        chk("midrst_bit_out", 64'(bo8), 64'(0));
        chk("midrst_bit_valid", 64'(bv8), 64'(0));
        chk("midrst_bit_first", 64'(bf8), 64'(0));
        chk("midrst_bit_last", 64'(bl8), 64'(0));
        chk("midrst_ready_still_rst", 64'(wr8), 64'(0));
        rst = 1'b0;
        #1;
        chk("midrst_ready_after", 64'(wr8), 64'(1));
        for (int i = 0; i < 12; i++) begin
            #1;
            chk("midrst_no_resume", 64'(bv8), 64'(0));
            step();
        end

        // 1-bit words 1,0,1; each must drain before the buffer can refill
        l1[0] = 1'b1; l1[1] = 1'b0; l1[2] = 1'b1;
        k = 0; pulses = 0;
        wi1 = l1[0]; wv1 = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (bv1) begin
                chk("w1_first", 64'(bf1), 64'(1));
                chk("w1_last", 64'(bl1), 64'(1));
                pulses++;
            end
            acc = wv1 && wr1;
            step();
            if (acc) begin
                k++;
                if (k < 3) wi1 = l1[k];
                else wv1 = 1'b0;
            end
        end
        chk("w1_pulse_count", 64'(pulses), 64'(3));

        // random traffic with random stalls on all three configurations
        for (int c = 0; c < 400; c++) begin
            wv8 = 1'($urandom_range(0, 1)); wi8 = 8'($urandom); h8 = ($urandom_range(0, 3) == 0);
            wv4 = 1'($urandom_range(0, 1)); wi4 = 4'($urandom); h4 = ($urandom_range(0, 3) == 0);
            wv1 = 1'($urandom_range(0, 1)); wi1 = 1'($urandom); h1 = ($urandom_range(0, 3) == 0);
            step();
        end
        wv8 = 1'b0; h8 = 1'b0;
        wv4 = 1'b0; h4 = 1'b0;
        wv1 = 1'b0; h1 = 1'b0;
        repeat (30) step();
        chk("drain_d8_empty", 64'(q8.size()), 64'(0));
        chk("drain_d4_empty", 64'(q4.size()), 64'(0));
        chk("drain_d1_empty", 64'(q1.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
